// File: rtl/instr_decode_pkg.sv
// Field layout, decoded bundle and decode helper for the decode stage.
// Shared by the prefetch buffer top level and anything consuming its fields.
package instr_decode_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 28;
    localparam int OPC_HI   = 26;
    localparam int OPC_LO   = 23;
    localparam int C11_HI   = 22;
    localparam int C11_LO   = 12;
    localparam int C16_HI   = 27;
    localparam int C16_LO   = 12;
    localparam int C27_HI   = 27;
    localparam int C27_LO   = 1;
    localparam int AREG_HI  = 11;
    localparam int AREG_LO  = 8;
    localparam int BREG_HI  = 7;
    localparam int BREG_LO  = 4;
    localparam int DREG_HI  = 3;
    localparam int DREG_LO  = 0;
    localparam int CE_BIT   = 27;
    localparam int HE_BIT   = 8;
    localparam int OE_BIT   = 0;
    localparam int INTF_BIT = 4;
    localparam int N1_BIT   = 0;
    localparam int N2_BIT   = 5;
    localparam int SIG_BIT  = 0;

    typedef struct packed {
        logic [3:0]  instr_op;
        logic [3:0]  opcode;
        logic [31:0] const11;
        logic [31:0] const16;
        logic [31:0] const27;
        logic [3:0]  areg;
        logic [3:0]  breg;
        logic [3:0]  dreg;
        logic        ce;
        logic        he;
        logic        oe;
        logic        intf;
        logic        n1;
        logic        n2;
        logic        sig;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] w, input logic sext);
        decoded_t d;
        d.instr_op = w[OP_HI:OP_LO];
        d.opcode   = w[OPC_HI:OPC_LO];
        d.const11  = {{21{sext & w[C11_HI]}}, w[C11_HI:C11_LO]};
        d.const16  = {{16{sext & w[C16_HI]}}, w[C16_HI:C16_LO]};
        d.const27  = {5'b0, w[C27_HI:C27_LO]};
        d.areg     = w[AREG_HI:AREG_LO];
        d.breg     = w[BREG_HI:BREG_LO];
        d.dreg     = w[DREG_HI:DREG_LO];
        d.ce       = w[CE_BIT];
        d.he       = w[HE_BIT];
        d.oe       = w[OE_BIT];
        d.intf     = w[INTF_BIT];
        d.n1       = w[N1_BIT];
        d.n2       = w[N2_BIT];
        d.sig      = w[SIG_BIT];
        return d;
    endfunction

endpackage

// File: rtl/instr_decode_buffer_fifo.sv
// Synchronous FIFO holding {instr, pc} words ahead of the output register.
// Push when full and pop when empty are ignored, so count never leaves 0..DEPTH.
module instr_fifo #(
    parameter int W     = 59,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/instr_decode_buffer.sv
// Decode stage: prefetch FIFO with bypass, registered output word and
// combinational field decode under valid/ready backpressure.
module instr_decode_buffer
    import instr_decode_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 27,
    parameter int SEXT_CONST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [3:0]             instr_op,
    output logic [3:0]             opcode,
    output logic [31:0]            const11,
    output logic [31:0]            const16,
    output logic [31:0]            const27,
    output logic [3:0]             areg,
    output logic [3:0]             breg,
    output logic [3:0]             dreg,
    output logic                   ce,
    output logic                   he,
    output logic                   oe,
    output logic                   intf,
    output logic                   n1,
    output logic                   n2,
    output logic                   sig,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int W = 32 + PC_W;

    logic [W-1:0]    w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_load;
    logic            w_fifo_push;
    logic            w_fifo_pop;
    logic            r_valid;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc;
    decoded_t        w_dec;

    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_load      = !r_valid || out_ready;
    assign w_fifo_pop  = w_load && !w_empty;
    // Incoming word skips the FIFO only when it is empty and the output reg is loading.
    assign w_fifo_push = w_push && !(w_load && w_empty);

    instr_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   ({in_instr, in_pc}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            if (!w_empty) begin
                {r_instr, r_pc} <= w_head;
                r_valid         <= 1'b1;
            end else if (w_push) begin
                r_instr <= in_instr;
                r_pc    <= in_pc;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign w_dec     = decode(r_instr, SEXT_CONST != 0);
    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign instr_op  = w_dec.instr_op;
    assign opcode    = w_dec.opcode;
    assign const11   = w_dec.const11;
    assign const16   = w_dec.const16;
    assign const27   = w_dec.const27;
    assign areg      = w_dec.areg;
    assign breg      = w_dec.breg;
    assign dreg      = w_dec.dreg;
    assign ce        = w_dec.ce;
    assign he        = w_dec.he;
    assign oe        = w_dec.oe;
    assign intf      = w_dec.intf;
    assign n1        = w_dec.n1;
    assign n2        = w_dec.n2;
    assign sig       = w_dec.sig;

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Bench for instr_decode_buffer: directed scenarios plus random traffic,
// checked against a queue model of all words held by the stage.
module tb_instr_decode_buffer;

    localparam int DEPTH = 4;
    localparam int PC_W  = 27;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            out_ready = 1'b0;

    logic            in_ready, out_valid;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      instr_op, opcode, areg, breg, dreg;
    logic [31:0]     const11, const16, const27;
    logic            ce, he, oe, intf, n1, n2, sig;
    logic [2:0]      occupancy;

    logic            z_in_ready, z_out_valid;
    logic [PC_W-1:0] z_out_pc;
    logic [3:0]      z_instr_op, z_opcode, z_areg, z_breg, z_dreg;
    logic [31:0]     z_const11, z_const16, z_const27;
    logic            z_ce, z_he, z_oe, z_intf, z_n1, z_n2, z_sig;
    logic [2:0]      z_occupancy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] op, opc, c11, c16, c27, ar, br, dr;
        logic [31:0] ce, he, oe, intf, n1, n2, sig;
    } exp_t;

    ent_t q[$];
    bit   m_zero = 1'b0;

    always #5 clk = ~clk;

    instr_decode_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .SEXT_CONST(1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .instr_op(instr_op), .opcode(opcode),
        .const11(const11), .const16(const16), .const27(const27),
        .areg(areg), .breg(breg), .dreg(dreg),
        .ce(ce), .he(he), .oe(oe), .intf(intf),
        .n1(n1), .n2(n2), .sig(sig), .occupancy(occupancy)
    );

    instr_decode_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .SEXT_CONST(0)) u_zx (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(z_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_pc(z_out_pc),
        .instr_op(z_instr_op), .opcode(z_opcode),
        .const11(z_const11), .const16(z_const16), .const27(z_const27),
        .areg(z_areg), .breg(z_breg), .dreg(z_dreg),
        .ce(z_ce), .he(z_he), .oe(z_oe), .intf(z_intf),
        .n1(z_n1), .n2(z_n2), .sig(z_sig), .occupancy(z_occupancy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w, input bit sext);
        exp_t e;
        e.op   = (w >> 28) & 32'hF;
        e.opc  = (w >> 23) & 32'hF;
        e.c11  = (w >> 12) & 32'h7FF;
        if (sext && e.c11 >= 32'h400) e.c11 = e.c11 | 32'hFFFF_F800;
        e.c16  = (w >> 12) & 32'hFFFF;
        if (sext && e.c16 >= 32'h8000) e.c16 = e.c16 | 32'hFFFF_0000;
        e.c27  = (w >> 1) & 32'h07FF_FFFF;
        e.ar   = (w >> 8) & 32'hF;
        e.br   = (w >> 4) & 32'hF;
        e.dr   = w & 32'hF;
        e.ce   = (w >> 27) & 32'h1;
        e.he   = (w >> 8) & 32'h1;
        e.oe   = w & 32'h1;
        e.intf = (w >> 4) & 32'h1;
        e.n1   = w & 32'h1;
        e.n2   = (w >> 5) & 32'h1;
        e.sig  = w & 32'h1;
        return e;
    endfunction

    function automatic logic [122:0] pack(input exp_t e);
        return {e.op[3:0], e.opc[3:0], e.c11, e.c16, e.c27,
                e.ar[3:0], e.br[3:0], e.dr[3:0], e.ce[0], e.he[0],
                e.oe[0], e.intf[0], e.n1[0], e.n2[0], e.sig[0]};
    endfunction

    task automatic chk_fields(input logic [31:0] w, input logic [PC_W-1:0] pc);
        exp_t e1;
        exp_t e0;
        e1 = ref_dec(w, 1'b1);
        e0 = ref_dec(w, 1'b0);
        chk("out_pc",   128'(out_pc),   128'(pc));
        chk("instr_op", 128'(instr_op), 128'(e1.op));
        chk("opcode",   128'(opcode),   128'(e1.opc));
        chk("const11",  128'(const11),  128'(e1.c11));
        chk("const16",  128'(const16),  128'(e1.c16));
        chk("const27",  128'(const27),  128'(e1.c27));
        chk("areg",     128'(areg),     128'(e1.ar));
        chk("breg",     128'(breg),     128'(e1.br));
        chk("dreg",     128'(dreg),     128'(e1.dr));
        chk("flags",    128'({ce, he, oe, intf, n1, n2, sig}),
            128'({e1.ce[0], e1.he[0], e1.oe[0], e1.intf[0],
                  e1.n1[0], e1.n2[0], e1.sig[0]}));
        chk("z_out_pc", 128'(z_out_pc), 128'(pc));
        chk("z_fields",
            128'({z_instr_op, z_opcode, z_const11, z_const16, z_const27,
                  z_areg, z_breg, z_dreg, z_ce, z_he, z_oe, z_intf,
                  z_n1, z_n2, z_sig}),
            128'(pack(e0)));
    endtask

    task automatic check_all();
        int sz;
        int occ;
        sz  = q.size();
        occ = (sz == 0) ? 0 : sz - 1;
        chk("out_valid",   128'(out_valid),   128'(sz > 0));
        chk("occupancy",   128'(occupancy),   128'(occ));
        chk("in_ready",    128'(in_ready),    128'(occ != DEPTH));
        chk("z_out_valid", 128'(z_out_valid), 128'(sz > 0));
        chk("z_occupancy", 128'(z_occupancy), 128'(occ));
        chk("z_in_ready",  128'(z_in_ready),  128'(occ != DEPTH));
        if (sz > 0) chk_fields(q[0].instr, q[0].pc);
        else if (m_zero) chk_fields('0, '0);
    endtask

    // Check current outputs, advance the model over one clock edge.
    task automatic step();
        int  occ;
        bit  rdy;
        @(negedge clk);
        check_all();
        occ = (q.size() == 0) ? 0 : q.size() - 1;
        rdy = (occ != DEPTH);
        if (reset) begin
            q.delete();
            m_zero = 1'b1;
        end else if (flush) begin
            q.delete();
            m_zero = 1'b0;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back('{in_instr, in_pc});
                m_zero = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_word();
        in_instr = $urandom;
        in_pc    = PC_W'($urandom);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        m_zero = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(1));

        // Single word through the bypass path
        in_valid = 1'b1; in_instr = 32'h1234_5678; in_pc = 27'h10;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_op",    128'(instr_op),  128'(4'h1));
        chk("t1_areg",  128'(areg),      128'(4'h6));
        chk("t1_breg",  128'(breg),      128'(4'h7));
        chk("t1_dreg",  128'(dreg),      128'(4'h8));
        chk("t1_pc",    128'(out_pc),    128'(27'h10));
        chk("t1_occ",   128'(occupancy), 128'(0));

        // Constant extension
        in_valid = 1'b1; in_instr = 32'h0040_0000; in_pc = 27'h14;
        step();
        in_valid = 1'b0;
        chk("t2_c11_sx", 128'(const11),   128'(32'hFFFF_FC00));
        chk("t2_c16_sx", 128'(const16),   128'(32'h0000_0400));
        chk("t2_c11_zx", 128'(z_const11), 128'(32'h0000_0400));
        step();

        // Fill under backpressure, then drain
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            rnd_word();
            step();
        end
        chk("t3_in_ready", 128'(in_ready),  128'(0));
        chk("t3_occ",      128'(occupancy), 128'(DEPTH));
        for (int i = 0; i < 2; i++) begin
            rnd_word();
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) step();

        // Full-rate streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rnd_word();
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Flush with three words queued and a word presented
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_word();
            step();
        end
        chk("t5_pre_occ", 128'(occupancy), 128'(3));
        flush = 1'b1;
        rnd_word();
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid",    128'(out_valid), 128'(0));
        chk("t5_occ",      128'(occupancy), 128'(0));
        chk("t5_in_ready", 128'(in_ready),  128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Reset while full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rnd_word();
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("t6_valid", 128'(out_valid), 128'(0));
        chk("t6_occ",   128'(occupancy), 128'(0));
        chk("t6_rdy",   128'(in_ready),  128'(1));
        chk("t6_pc",    128'(out_pc),    128'(0));
        chk("t6_op",    128'(instr_op),  128'(0));
        chk("t6_c27",   128'(const27),   128'(0));
        step();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 150) == 0);
            rnd_word();
            step();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
